apb_i2c_slave_regs: RTL and testbench

APB slave register block that sits directly downstream of the board-level APB master and fronts the I2C master engine. It decodes single-cycle APB accesses into control, status and data registers. It buffers transmit bytes in a 4-deep FIFO and holds one received byte. It drives command and configuration signals to the I2C engine.

---
 rtl/apb_i2c_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 56 +++++
 rtl/apb_i2c_slave_regs.sv | 175 +++++++++++++++++
 tb/tb_apb_i2c_slave_regs.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_i2c_pkg.sv
// Purpose: shared register map, bit positions and reset defaults for the APB I2C register block.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: APB byte addresses, CTRL/STATUS bit positions, SCL prescaler reset default.
package apb_i2c_pkg;

  // Register byte addresses (paddr[7:0])
  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_STATUS   = 8'h04;
  localparam logic [7:0] ADDR_TXDATA   = 8'h08;
  localparam logic [7:0] ADDR_RXDATA   = 8'h0C;
  localparam logic [7:0] ADDR_PRESCALE = 8'h10;
  localparam logic [7:0] ADDR_SLVADDR  = 8'h14;

  // CTRL bit positions
  localparam int CTRL_EN    = 0;
  localparam int CTRL_START = 1;
  localparam int CTRL_STOP  = 2;
  localparam int CTRL_RW    = 3;
  localparam int CTRL_ACK   = 4;

  // STATUS bit positions
  localparam int ST_BUSY     = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_NACK     = 4;
  localparam int ST_TX_OVF   = 5;
  localparam int ST_RX_OVF   = 6;

  localparam logic [7:0] PRESCALE_RST_DEF = 8'h63;

endpackage

// File: rtl/sync_fifo.sv
// Purpose: generic single-clock FIFO with occupancy count.
// Latency: push visible at dout/empty one cycle after the pushing edge; dout shows the head combinationally.
// Backpressure: push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
// Ports: pclk/prst_n (sync active-low), push/din, pop/dout, full, empty, count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             pclk,
  input  logic             prst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // A simultaneous pop frees the slot this push lands in, so a full FIFO still accepts it.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge pclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge pclk) begin
    if (!prst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/apb_i2c_slave_regs.sv
// Purpose: APB register front-end for the I2C master engine (control, status, TX FIFO, RX holding reg).
// Latency: writes take effect one cycle after the access edge; prdata is registered from the current paddr.
// Backpressure: no APB wait states; TX writes to a full FIFO are dropped (tx_ovf), RX overruns overwrite (rx_ovf).
// Ports: APB slave (pclk, prst_n, psel, penable, pwrite, paddr, pwdata, prdata);
//        engine side: cmd_start/cmd_stop pulses, cmd_rw, ack_en, core_en, slv_addr, prescale,
//        tx_data/tx_valid/tx_pop, rx_data/rx_valid, busy, nack.
module apb_i2c_slave_regs
  import apb_i2c_pkg::*;
#(
  parameter int unsigned TX_DEPTH     = 4,
  parameter logic [7:0]  PRESCALE_RST = PRESCALE_RST_DEF
) (
  input  logic        pclk,
  input  logic        prst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        cmd_start,
  output logic        cmd_stop,
  output logic        cmd_rw,
  output logic        ack_en,
  output logic        core_en,
  output logic [6:0]  slv_addr,
  output logic [7:0]  prescale,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_pop,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        busy,
  input  logic        nack
);

  localparam int unsigned TX_AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;

  logic [7:0]     addr;
  logic           wr_en;
  logic           rd_en;
  logic           wr_ctrl;
  logic           wr_status;
  logic           wr_tx;
  logic           wr_pre;
  logic           wr_slv;
  logic           rd_rx;

  logic           tx_full;
  logic           tx_empty;
  logic [7:0]     tx_head;
  logic [TX_AW:0] tx_count;

  logic           nack_sticky;
  logic           tx_ovf;
  logic           rx_ovf;
  logic           rx_full;
  logic [7:0]     rx_hold;
  logic           tx_ovf_set;
  logic           rx_ovf_set;
  logic [7:0]     status;
  logic [7:0]     rd_mux;

  // Upper bus bits and FIFO occupancy are deliberately not used by this block.
  logic unused_ok;
  assign unused_ok = ^{paddr[31:8], pwdata[31:8], tx_count};

  // Single-cycle APB: psel and penable arrive together.
  assign addr      = paddr[7:0];
  assign wr_en     = psel & penable & pwrite;
  assign rd_en     = psel & penable & ~pwrite;
  assign wr_ctrl   = wr_en & (addr == ADDR_CTRL);
  assign wr_status = wr_en & (addr == ADDR_STATUS);
  assign wr_tx     = wr_en & (addr == ADDR_TXDATA);
  assign wr_pre    = wr_en & (addr == ADDR_PRESCALE);
  assign wr_slv    = wr_en & (addr == ADDR_SLVADDR);
  assign rd_rx     = rd_en & (addr == ADDR_RXDATA);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .pclk   (pclk),
    .prst_n (prst_n),
    .push   (wr_tx),
    .din    (pwdata[7:0]),
    .pop    (tx_pop),
    .dout   (tx_head),
    .full   (tx_full),
    .empty  (tx_empty),
    .count  (tx_count)
  );

  assign tx_valid = ~tx_empty;
  // Stale storage is hidden so tx_data is 0 whenever nothing is queued.
  assign tx_data  = tx_empty ? 8'h00 : tx_head;

  // A full-FIFO write is only lost when no pop frees a slot in the same cycle.
  assign tx_ovf_set = wr_tx & tx_full & ~tx_pop;
  // Reading RXDATA in the same cycle as a new byte is a clean hand-off, not an overrun.
  assign rx_ovf_set = rx_valid & rx_full & ~rd_rx;

  always_comb begin
    status              = 8'h00;
    status[ST_BUSY]     = busy;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_NACK]     = nack_sticky;
    status[ST_TX_OVF]   = tx_ovf;
    status[ST_RX_OVF]   = rx_ovf;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (addr)
      ADDR_CTRL: begin
        rd_mux[CTRL_EN]  = core_en;
        rd_mux[CTRL_RW]  = cmd_rw;
        rd_mux[CTRL_ACK] = ack_en;
      end
      ADDR_STATUS:   rd_mux = status;
      ADDR_RXDATA:   rd_mux = rx_hold;
      ADDR_PRESCALE: rd_mux = prescale;
      ADDR_SLVADDR:  rd_mux = {1'b0, slv_addr};
      default:       rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!prst_n) begin
      prdata      <= '0;
      cmd_start   <= 1'b0;
      cmd_stop    <= 1'b0;
      cmd_rw      <= 1'b0;
      ack_en      <= 1'b0;
      core_en     <= 1'b0;
      slv_addr    <= '0;
      prescale    <= PRESCALE_RST;
      nack_sticky <= 1'b0;
      tx_ovf      <= 1'b0;
      rx_ovf      <= 1'b0;
      rx_full     <= 1'b0;
      rx_hold     <= '0;
    end else begin
      // prdata tracks paddr every cycle so the master can sample it ahead of the access.
      prdata <= {24'h0, rd_mux};

      // Commands are gated by the enable already in force, not the one being written.
      cmd_start <= wr_ctrl & pwdata[CTRL_START] & core_en & ~busy;
      cmd_stop  <= wr_ctrl & pwdata[CTRL_STOP]  & core_en & ~busy;

      if (wr_ctrl) begin
        core_en <= pwdata[CTRL_EN];
        cmd_rw  <= pwdata[CTRL_RW];
        ack_en  <= pwdata[CTRL_ACK];
      end
      if (wr_pre) prescale <= pwdata[7:0];
      if (wr_slv) slv_addr <= pwdata[6:0];

      // Sticky flags: a set event in the same cycle as a W1C keeps the bit set.
      nack_sticky <= nack       | (nack_sticky & ~(wr_status & pwdata[ST_NACK]));
      tx_ovf      <= tx_ovf_set | (tx_ovf      & ~(wr_status & pwdata[ST_TX_OVF]));
      rx_ovf      <= rx_ovf_set | (rx_ovf      & ~(wr_status & pwdata[ST_RX_OVF]));

      if (rx_valid) begin
        rx_hold <= rx_data;
        rx_full <= 1'b1;
      end else if (rd_rx) begin
        rx_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apb_i2c_slave_regs.sv
// Purpose: self-checking bench for apb_i2c_slave_regs (directed register scenarios plus random traffic).
// Latency: expected outputs are queued one per cycle and compared 1 time unit after each rising edge.
// Backpressure: n/a (bench drives every cycle).
module tb_apb_i2c_slave_regs;

  localparam int TX_DEPTH = 4;

  logic        pclk = 1'b0;
  logic        prst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata;
  logic        cmd_start, cmd_stop, cmd_rw, ack_en, core_en;
  logic [6:0]  slv_addr;
  logic [7:0]  prescale, tx_data;
  logic        tx_valid;
  logic        tx_pop = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0, busy = 1'b0, nack = 1'b0;

  always #5 pclk = ~pclk;

  apb_i2c_slave_regs #(.TX_DEPTH(TX_DEPTH), .PRESCALE_RST(8'h63)) dut (
    .pclk(pclk), .prst_n(prst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_rw(cmd_rw), .ack_en(ack_en),
    .core_en(core_en), .slv_addr(slv_addr), .prescale(prescale),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_pop(tx_pop),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .nack(nack)
  );

  typedef struct packed {
    logic [31:0] prdata;
    logic        cmd_start, cmd_stop, cmd_rw, ack_en, core_en;
    logic [6:0]  slv_addr;
    logic [7:0]  prescale, tx_data;
    logic        tx_valid;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model state
  bit          m_en, m_rw, m_ack, m_nack, m_txovf, m_rxovf, m_rxf;
  int unsigned m_pre, m_rx, m_slv;
  int unsigned m_fifo[$];
  bit          cur_busy = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endfunction

  // Computes the outputs expected after the coming edge from the inputs now applied.
  task automatic model_step();
    obs_t        e;
    int unsigned a, pr, wd;
    bit          wr, rd, pop_ok, was_full, st_w;
    e  = '0;
    a  = paddr[7:0];
    wd = pwdata[7:0];
    wr = psel && penable && pwrite;
    rd = psel && penable && !pwrite;
    if (!prst_n) begin
      {m_en, m_rw, m_ack, m_nack, m_txovf, m_rxovf, m_rxf} = '0;
      m_pre = 'h63; m_rx = 0; m_slv = 0;
      m_fifo.delete();
    end else begin
      case (a)
        'h00:    pr = m_en + 8*m_rw + 16*m_ack;
        'h04:    pr = busy + 2*(m_fifo.size() == TX_DEPTH) + 4*(m_fifo.size() == 0) + 8*m_rxf
                      + 16*m_nack + 32*m_txovf + 64*m_rxovf;
        'h0C:    pr = m_rx;
        'h10:    pr = m_pre;
        'h14:    pr = m_slv;
        default: pr = 0;
      endcase
      e.prdata    = pr;
      e.cmd_start = wr && a == 'h00 && wd[1] && m_en && !busy;
      e.cmd_stop  = wr && a == 'h00 && wd[2] && m_en && !busy;
      st_w = wr && a == 'h04;
      if (st_w && wd[4]) m_nack  = 0;
      if (st_w && wd[5]) m_txovf = 0;
      if (st_w && wd[6]) m_rxovf = 0;
      if (nack) m_nack = 1;
      was_full = (m_fifo.size() == TX_DEPTH);
      pop_ok   = tx_pop && m_fifo.size() > 0;
      if (pop_ok) void'(m_fifo.pop_front());
      if (wr && a == 'h08) begin
        if (!was_full || pop_ok) m_fifo.push_back(wd);
        else m_txovf = 1;
      end
      if (rx_valid) begin
        if (m_rxf && !(rd && a == 'h0C)) m_rxovf = 1;
        m_rx = rx_data; m_rxf = 1;
      end else if (rd && a == 'h0C) begin
        m_rxf = 0;
      end
      if (wr && a == 'h00) begin m_en = wd[0]; m_rw = wd[3]; m_ack = wd[4]; end
      if (wr && a == 'h10) m_pre = wd;
      if (wr && a == 'h14) m_slv = wd % 128;
    end
    e.core_en  = m_en;
    e.cmd_rw   = m_rw;
    e.ack_en   = m_ack;
    e.prescale = m_pre[7:0];
    e.slv_addr = m_slv[6:0];
    e.tx_valid = m_fifo.size() > 0;
    e.tx_data  = (m_fifo.size() > 0) ? m_fifo[0][7:0] : 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit rn, input bit acc, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input bit pop, input bit rxv,
                       input logic [7:0] rxd, input bit bsy, input bit nk);
    @(negedge pclk);
    prst_n = rn; psel = acc; penable = acc; pwrite = wr; paddr = a; pwdata = wd;
    tx_pop = pop; rx_valid = rxv; rx_data = rxd; busy = bsy; nack = nk;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, paddr, 0, 0, 0, 0, cur_busy, 0);
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    drive(1, 1, 1, a, d, 0, 0, 0, cur_busy, 0);
  endtask

  // Address phase first so prdata is already valid, then the access itself.
  task automatic rd_reg(input logic [31:0] a);
    drive(1, 0, 0, a, 0, 0, 0, 0, cur_busy, 0);
    drive(1, 1, 0, a, 0, 0, 0, 0, cur_busy, 0);
  endtask

  // Monitor: one expected record per clock edge.
  initial begin
    obs_t e, act;
    forever begin
      @(posedge pclk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {prdata, cmd_start, cmd_stop, cmd_rw, ack_en, core_en, slv_addr, prescale,
               tx_data, tx_valid};
        chk("prdata",    act.prdata,    e.prdata);
        chk("cmd_start", act.cmd_start, e.cmd_start);
        chk("cmd_stop",  act.cmd_stop,  e.cmd_stop);
        chk("cmd_rw",    act.cmd_rw,    e.cmd_rw);
        chk("ack_en",    act.ack_en,    e.ack_en);
        chk("core_en",   act.core_en,   e.core_en);
        chk("slv_addr",  act.slv_addr,  e.slv_addr);
        chk("prescale",  act.prescale,  e.prescale);
        chk("tx_data",   act.tx_data,   e.tx_data);
        chk("tx_valid",  act.tx_valid,  e.tx_valid);
      end
    end
  end

  initial begin
    logic [7:0] ra;
    // Reset
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rd_reg(32'h10);
    rd_reg(32'h04);
    // Config
    wr_reg(32'h14, 32'h50);
    wr_reg(32'h00, 32'h19);
    idle(1);
    rd_reg(32'h00);
    // Start/stop pulses, then blocked by busy
    wr_reg(32'h00, 32'h03);
    idle(2);
    wr_reg(32'h00, 32'h05);
    idle(1);
    cur_busy = 1;
    wr_reg(32'h00, 32'h03);
    idle(2);
    cur_busy = 0;
    // TX FIFO fill, overflow, drain
    wr_reg(32'h08, 32'hA1); wr_reg(32'h08, 32'hA2);
    wr_reg(32'h08, 32'hA3); wr_reg(32'h08, 32'hA4);
    rd_reg(32'h04);
    wr_reg(32'h08, 32'hA5);
    rd_reg(32'h04);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 32'h04, 0, 1, 0, 0, 0, 0);
      idle(1);
    end
    rd_reg(32'h04);
    wr_reg(32'h04, 32'h20);
    // Push and pop together: at empty, then at full
    drive(1, 1, 1, 32'h08, 32'hB0, 1, 0, 0, 0, 0);
    wr_reg(32'h08, 32'hB1); wr_reg(32'h08, 32'hB2); wr_reg(32'h08, 32'hB3);
    drive(1, 1, 1, 32'h08, 32'hB4, 1, 0, 0, 0, 0);
    rd_reg(32'h04);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 32'h04, 0, 1, 0, 0, 0, 0);
    // RX overrun, read, simultaneous load and read
    drive(1, 0, 0, 32'h04, 0, 0, 1, 8'h3C, 0, 0);
    drive(1, 0, 0, 32'h04, 0, 0, 1, 8'h5A, 0, 0);
    rd_reg(32'h04);
    rd_reg(32'h0C);
    rd_reg(32'h04);
    drive(1, 0, 0, 32'h0C, 0, 0, 1, 8'h11, 0, 0);
    drive(1, 1, 0, 32'h0C, 0, 0, 1, 8'h77, 0, 0);
    rd_reg(32'h04);
    rd_reg(32'h0C);
    wr_reg(32'h04, 32'h40);
    rd_reg(32'h04);
    // Sticky nack with W1C, then set-wins collision
    drive(1, 0, 0, 32'h04, 0, 0, 0, 0, 0, 1);
    rd_reg(32'h04);
    wr_reg(32'h04, 32'h10);
    rd_reg(32'h04);
    drive(1, 1, 1, 32'h04, 32'h10, 0, 0, 0, 0, 1);
    rd_reg(32'h04);
    // Reset mid-transfer while a start is being written
    wr_reg(32'h00, 32'h01);
    wr_reg(32'h08, 32'hC1); wr_reg(32'h08, 32'hC2);
    drive(0, 1, 1, 32'h00, 32'h03, 0, 0, 0, 0, 0);
    idle(3);
    rd_reg(32'h04);
    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 7))
        0: ra = 8'h00; 1: ra = 8'h04; 2: ra = 8'h08; 3: ra = 8'h0C;
        4: ra = 8'h10; 5: ra = 8'h14; 6: ra = 8'h18; default: ra = 8'hFC;
      endcase
      drive(($urandom_range(0, 199) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
            {24'($urandom), ra}, $urandom, ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 4) == 0), 8'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) == 0));
    end
    idle(2);
    @(posedge pclk);
    #3;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
